// File: rtl/fir_band_sched.sv
// Time-shares one FIR MAC engine across NUM_BANDS equalizer bands: sequences
// NUM_TAPS+1 MAC cycles per band and latches each band's stereo result.
module fir_band_sched #(
    parameter int NUM_BANDS = 4,
    parameter int NUM_TAPS  = 1021,
    parameter int DATA_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          new_smpl,
    input  logic signed [DATA_W-1:0]      lft_fir,
    input  logic signed [DATA_W-1:0]      rght_fir,
    output logic                          sequencing,
    output logic [2:0]                    band_sel,
    output logic [DATA_W*NUM_BANDS-1:0]   lft_band,
    output logic [DATA_W*NUM_BANDS-1:0]   rght_band,
    output logic                          frame_done,
    output logic                          busy,
    output logic                          overrun
);

    localparam int CNT_W = $clog2(NUM_TAPS + 1);
    localparam logic [CNT_W-1:0] TAP_LAST  = CNT_W'(NUM_TAPS);
    localparam logic [2:0]       BAND_LAST = 3'(NUM_BANDS - 1);

    typedef enum logic [1:0] {IDLE, SEQ, GAP, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] tap_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tap_cnt    <= '0;
            band_sel   <= '0;
            sequencing <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            lft_band   <= '0;
            rght_band  <= '0;
        end else begin
            // Any sample arriving outside IDLE (DONE included) is dropped and flagged.
            if (new_smpl && state != IDLE)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (new_smpl) begin
                        state      <= SEQ;
                        tap_cnt    <= '0;
                        band_sel   <= '0;
                        sequencing <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                SEQ: begin
                    tap_cnt <= tap_cnt + CNT_W'(1);
                    if (tap_cnt == TAP_LAST) begin
                        state      <= GAP;
                        sequencing <= 1'b0;
                    end
                end
                GAP: begin
                    // The engine's result is settled by the end of the idle gap cycle.
                    for (int b = 0; b < NUM_BANDS; b++) begin
                        if (band_sel == 3'(b)) begin
                            lft_band[DATA_W*b +: DATA_W]  <= lft_fir;
                            rght_band[DATA_W*b +: DATA_W] <= rght_fir;
                        end
                    end
                    if (band_sel < BAND_LAST) begin
                        band_sel   <= band_sel + 3'd1;
                        tap_cnt    <= '0;
                        state      <= SEQ;
                        sequencing <= 1'b1;
                    end else begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    band_sel   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_band_sched.sv
// Bench for fir_band_sched: cycle-timeline reference model, frame scoreboard,
// and a default-parameter instance for full-length timing.
module tb_fir_band_sched;

    localparam int NB = 4;
    localparam int NT = 4;
    localparam int FL = NB * (NT + 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               new_smpl;
    logic [15:0]        salt;
    logic signed [15:0] lft_fir, rght_fir;
    logic               sequencing, frame_done, busy, overrun;
    logic [2:0]         band_sel;
    logic [63:0]        lft_band, rght_band;

    // Model FIR engine: result identifies the band that was sequenced.
    assign lft_fir  = 16'h1000 + 16'(band_sel) + salt;
    assign rght_fir = 16'h8000 + 16'(band_sel) + salt;

    fir_band_sched #(.NUM_BANDS(NB), .NUM_TAPS(NT)) dut (
        .clk(clk), .rst(rst), .new_smpl(new_smpl),
        .lft_fir(lft_fir), .rght_fir(rght_fir),
        .sequencing(sequencing), .band_sel(band_sel),
        .lft_band(lft_band), .rght_band(rght_band),
        .frame_done(frame_done), .busy(busy), .overrun(overrun)
    );

    logic               new2;
    logic signed [15:0] lf2, rf2;
    logic               seq2, fd2, busy2, ovr2;
    logic [2:0]         bs2;
    logic [63:0]        lb2, rb2;

    assign lf2 = 16'h7abc;
    assign rf2 = 16'h8123;

    fir_band_sched dut_dflt (
        .clk(clk), .rst(rst), .new_smpl(new2),
        .lft_fir(lf2), .rght_fir(rf2),
        .sequencing(seq2), .band_sel(bs2),
        .lft_band(lb2), .rght_band(rb2),
        .frame_done(fd2), .busy(busy2), .overrun(ovr2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int          done_cyc;
        logic [63:0] l;
        logic [63:0] r;
    } exp_t;
    exp_t q[$];

    int         cyc = 0;
    int         t0 = 0;
    bit         m_act = 0;
    bit         chk_on = 0;
    logic       e_seq = 0, e_fd = 0, e_busy = 0, e_ovr = 0;
    logic [2:0] e_bs = 0;

    function automatic void calc();
        int d, j;
        e_seq = 0; e_fd = 0; e_busy = 0; e_bs = 0;
        if (m_act) begin
            d = cyc - t0;
            if (d <= FL) begin
                j      = d - 1;
                e_bs   = 3'(j / (NT + 2));
                e_seq  = ((j % (NT + 2)) <= NT);
                e_busy = 1;
            end else if (d == FL + 1) begin
                e_bs   = 3'(NB - 1);
                e_fd   = 1;
                e_busy = 1;
            end else begin
                m_act = 0;
            end
        end
    endfunction

    // Reference model advances on the same edge the DUT samples inputs.
    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            m_act = 0;
            e_ovr = 0;
            q.delete();
        end else if (new_smpl) begin
            if (e_busy) e_ovr = 1;
            else begin
                m_act = 1;
                t0 = cyc;
                e.done_cyc = cyc + FL + 1;
                for (int b = 0; b < NB; b++) begin
                    e.l[16*b +: 16] = 16'h1000 + 16'(b) + salt;
                    e.r[16*b +: 16] = 16'h8000 + 16'(b) + salt;
                end
                q.push_back(e);
            end
        end
        cyc++;
        calc();
    end

    always @(negedge clk) begin
        exp_t e;
        if (chk_on) begin
            chk("sequencing", 64'(sequencing), 64'(e_seq));
            chk("band_sel",   64'(band_sel),   64'(e_bs));
            chk("busy",       64'(busy),       64'(e_busy));
            chk("frame_done", 64'(frame_done), 64'(e_fd));
            chk("overrun",    64'(overrun),    64'(e_ovr));
            if (frame_done) begin
                if (q.size() == 0) chk("fd_unexpected", 64'(frame_done), 64'd0);
                else begin
                    e = q.pop_front();
                    chk("fd_cycle",  64'(cyc), 64'(e.done_cyc));
                    chk("lft_band",  lft_band,  e.l);
                    chk("rght_band", rght_band, e.r);
                end
            end
        end
    end

    // Run lengths of the default instance's sequencing pulses.
    int run2 = 0;
    int widths[$];
    always @(negedge clk) begin
        if (seq2) run2++;
        else if (run2 > 0) begin
            widths.push_back(run2);
            run2 = 0;
        end
    end

    task automatic pulse();
        @(negedge clk); new_smpl = 1'b1;
        @(negedge clk); new_smpl = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || m_act) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("rst_lft",  lft_band,  64'd0);
        chk("rst_rght", rght_band, 64'd0);
        chk("rst_seq",  64'(sequencing), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ovr",  64'(overrun), 64'd0);
        chk("rst_bs",   64'(band_sel), 64'd0);
        chk("rst_fd",   64'(frame_done), 64'd0);
        rst = 1'b0;
    endtask

    initial begin
        int n, t2;
        rst = 1'b1; new_smpl = 1'b0; new2 = 1'b0; salt = 16'h0;
        repeat (3) @(negedge clk);
        chk_on = 1;
        do_reset();
        repeat (2) @(negedge clk);

        // Single frame with the plain model FIR values.
        pulse();
        wait_idle();
        chk("frame_lft",  lft_band,  64'h1003_1002_1001_1000);
        chk("frame_rght", rght_band, 64'h8003_8002_8001_8000);

        // Second sample arrives mid-frame, then a normal frame afterwards.
        salt = 16'h0010;
        pulse();
        repeat (8) @(negedge clk);
        new_smpl = 1'b1;
        @(negedge clk); new_smpl = 1'b0;
        wait_idle();
        chk("ovr_after_mid", 64'(overrun), 64'd1);
        salt = 16'h0020;
        pulse();
        wait_idle();
        chk("ovr_sticky", 64'(overrun), 64'd1);

        // Sample in DONE is dropped; the one in the following IDLE cycle starts a frame.
        do_reset();
        salt = 16'h0040;
        pulse();
        n = 0;
        while (!frame_done && n < 100) begin @(negedge clk); n++; end
        chk("done_wait", 64'(frame_done), 64'd1);
        salt = 16'h0050;
        new_smpl = 1'b1;
        @(negedge clk);
        @(negedge clk); new_smpl = 1'b0;
        chk("done_ovr", 64'(overrun), 64'd1);
        chk("done_restart_bs", 64'(band_sel), 64'd0);
        wait_idle();

        // Reset during band 2 aborts the frame cleanly.
        do_reset();
        salt = 16'h0060;
        pulse();
        n = 0;
        while (!(sequencing && band_sel == 3'd2) && n < 100) begin @(negedge clk); n++; end
        chk("band2_wait", 64'(band_sel), 64'd2);
        do_reset();
        repeat (30) @(negedge clk);
        salt = 16'h0070;
        pulse();
        wait_idle();

        // A few back-to-back frames with varied spacing and content.
        for (int k = 0; k < 3; k++) begin
            salt = 16'($urandom_range(0, 16'h0fff));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pulse();
            wait_idle();
        end
        chk("queue_drained", 64'(q.size()), 64'd0);

        // Full-length frame on the default-parameter instance.
        @(negedge clk); new2 = 1'b1; t2 = cyc;
        @(negedge clk); new2 = 1'b0;
        n = 0;
        while (!fd2 && n < 5000) begin @(negedge clk); n++; end
        chk("dflt_latency", 64'(cyc - t2), 64'd4093);
        chk("dflt_lft",  lb2, {4{16'h7abc}});
        chk("dflt_rght", rb2, {4{16'h8123}});
        repeat (2) @(negedge clk);
        chk("dflt_pulses", 64'(widths.size()), 64'd4);
        foreach (widths[i]) chk("dflt_width", 64'(widths[i]), 64'd1022);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
